// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, entry record and pointer helper for the reorder buffer.
package reorder_buffer_pkg;
    localparam int WORD_SIZE = 32;
    localparam int RB_SIZE   = 8;
    localparam int RB_INDEX  = 4;
    localparam int NULL      = 15;
    localparam int FU_NUM    = 4;
    localparam int REG_INDEX = 3;

    localparam int PTR_W = $clog2(RB_SIZE);
    localparam int CNT_W = $clog2(RB_SIZE + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 is_branch;
        logic [REG_INDEX-1:0] dest_reg;
        logic [WORD_SIZE-1:0] value;
    } rb_entry_t;

    // RB_SIZE is a power of two, so pointers wrap by natural overflow.
    function automatic ptr_t ptr_inc(ptr_t p);
        return p + ptr_t'(1);
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Issue/FU/CDB/commit signal bundle between the core and the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                                alloc_req;
    logic                                alloc_is_branch;
    logic [REG_INDEX-1:0]                alloc_dest_reg;
    logic                                alloc_ready;
    logic [RB_INDEX-1:0]                 alloc_index;
    logic [FU_NUM-1:0][WORD_SIZE-1:0]    data_bus;
    logic [FU_NUM-1:0]                   valid_bus;
    logic [FU_NUM-1:0][RB_INDEX-1:0]     RB_index_bus;
    logic [RB_SIZE-1:0][WORD_SIZE-1:0]   CDB_data_data;
    logic [RB_SIZE-1:0]                  CDB_data_valid;
    logic                                commit_valid;
    logic [REG_INDEX-1:0]                commit_reg;
    logic [WORD_SIZE-1:0]                commit_data;
    logic                                flush;
    logic [FU_NUM-1:0]                   reset_bus;

    modport master (
        output alloc_req, alloc_is_branch, alloc_dest_reg, data_bus, valid_bus, RB_index_bus,
        input  alloc_ready, alloc_index, CDB_data_data, CDB_data_valid,
               commit_valid, commit_reg, commit_data, flush, reset_bus
    );

    modport slave (
        input  alloc_req, alloc_is_branch, alloc_dest_reg, data_bus, valid_bus, RB_index_bus,
        output alloc_ready, alloc_index, CDB_data_data, CDB_data_valid,
               commit_valid, commit_reg, commit_data, flush, reset_bus
    );
endinterface

// File: rtl/reorder_buffer_capture.sv
// FU result to entry match: per-entry write enable and selected word.
module reorder_buffer_capture
    import reorder_buffer_pkg::*;
(
    input  logic [FU_NUM-1:0][WORD_SIZE-1:0]  data_bus,
    input  logic [FU_NUM-1:0]                 valid_bus,
    input  logic [FU_NUM-1:0][RB_INDEX-1:0]   RB_index_bus,
    input  logic [RB_SIZE-1:0]                busy,
    output logic [RB_SIZE-1:0]                we,
    output logic [RB_SIZE-1:0][WORD_SIZE-1:0] wdata
);
    // Ascending FU scan: a later (higher-numbered) FU overrides an earlier one.
    always_comb begin
        we    = '0;
        wdata = '0;
        for (int e = 0; e < RB_SIZE; e++) begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (valid_bus[i] && busy[e] &&
                    RB_index_bus[i] != RB_INDEX'(NULL) &&
                    RB_index_bus[i] == RB_INDEX'(e)) begin
                    we[e]    = 1'b1;
                    wdata[e] = data_bus[i];
                end
            end
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, FU result capture, in-order retire, branch flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    reorder_buffer_if.slave rb
);
    rb_entry_t [RB_SIZE-1:0]            ent;
    ptr_t                               head, tail;
    cnt_t                               count;
    logic [RB_SIZE-1:0]                 busy, cap_we;
    logic [RB_SIZE-1:0][WORD_SIZE-1:0]  cap_data;
    logic                               do_alloc, retire, take_flush;

    for (genvar e = 0; e < RB_SIZE; e++) begin : g_ent
        assign busy[e]              = ent[e].busy;
        assign rb.CDB_data_valid[e] = ent[e].busy & ent[e].done;
        assign rb.CDB_data_data[e]  = ent[e].value;
    end

    // Retire is decided from registered state, so a result is seen at commit one cycle after capture.
    assign retire     = (count != '0) && ent[head].done;
    assign take_flush = retire && ent[head].is_branch && ent[head].value[0];

    assign rb.alloc_ready  = (count < cnt_t'(RB_SIZE)) && !take_flush;
    assign rb.alloc_index  = RB_INDEX'(tail);
    assign do_alloc        = rb.alloc_req && rb.alloc_ready;

    assign rb.commit_valid = retire && !ent[head].is_branch;
    assign rb.commit_reg   = ent[head].dest_reg;
    assign rb.commit_data  = ent[head].value;
    assign rb.flush        = take_flush;
    assign rb.reset_bus    = {FU_NUM{take_flush}};

    reorder_buffer_capture u_capture (
        .data_bus     (rb.data_bus),
        .valid_bus    (rb.valid_bus),
        .RB_index_bus (rb.RB_index_bus),
        .busy         (busy),
        .we           (cap_we),
        .wdata        (cap_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (take_flush) begin
            ent   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int e = 0; e < RB_SIZE; e++) begin
                if (cap_we[e]) begin
                    ent[e].value <= cap_data[e];
                    ent[e].done  <= 1'b1;
                end
            end
            if (do_alloc) begin
                ent[tail].busy      <= 1'b1;
                ent[tail].done      <= 1'b0;
                ent[tail].is_branch <= rb.alloc_is_branch;
                ent[tail].dest_reg  <= rb.alloc_dest_reg;
                tail                <= ptr_inc(tail);
            end
            // Clearing the retiring entry overrides a late capture aimed at it.
            if (retire) begin
                ent[head] <= '0;
                head      <= ptr_inc(head);
            end
            count <= count + cnt_t'(do_alloc) - cnt_t'(retire);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order commit scoreboard.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    typedef struct {
        logic [REG_INDEX-1:0] rg;
        logic [WORD_SIZE-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    reorder_buffer_if rbif ();

    reorder_buffer dut (
        .clk   (clk),
        .reset (reset),
        .rb    (rbif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rbif.alloc_req       = 1'b0;
        rbif.alloc_is_branch = 1'b0;
        rbif.alloc_dest_reg  = '0;
        rbif.valid_bus       = '0;
        rbif.data_bus        = '0;
        for (int i = 0; i < FU_NUM; i++) rbif.RB_index_bus[i] = RB_INDEX'(NULL);
    endtask

    // Advance one edge, then check any commit against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rbif.commit_valid) begin
            if (exp_q.size() == 0) chk("unexpected_commit", rbif.commit_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("commit_reg", rbif.commit_reg, e.rg);
                chk("commit_data", rbif.commit_data, e.d);
            end
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic alloc(input logic br, input logic [REG_INDEX-1:0] rg, input int exp_idx);
        rbif.alloc_req       = 1'b1;
        rbif.alloc_is_branch = br;
        rbif.alloc_dest_reg  = rg;
        chk("alloc_ready", rbif.alloc_ready, 1);
        chk("alloc_index", rbif.alloc_index, exp_idx);
        tick();
        rbif.alloc_req       = 1'b0;
        rbif.alloc_is_branch = 1'b0;
    endtask

    task automatic set_fu(input int i, input int tag, input logic [WORD_SIZE-1:0] d);
        rbif.valid_bus[i]    = 1'b1;
        rbif.RB_index_bus[i] = RB_INDEX'(tag);
        rbif.data_bus[i]     = d;
    endtask

    task automatic push(input logic [REG_INDEX-1:0] rg, input logic [WORD_SIZE-1:0] d);
        exp_t e;
        e.rg = rg;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #12;
        chk("rst_commit_valid", rbif.commit_valid, 0);
        chk("rst_flush", rbif.flush, 0);
        chk("rst_reset_bus", rbif.reset_bus, 0);
        chk("rst_cdb_valid", rbif.CDB_data_valid, 0);
        chk("rst_cdb_data", |rbif.CDB_data_data, 0);
        reset = 1'b1;
        #1;
        chk("rst_alloc_ready", rbif.alloc_ready, 1);

        // Fill: 8 grants, then full.
        for (int k = 0; k < RB_SIZE; k++) alloc(1'b0, REG_INDEX'(k), k);
        chk("full_ready", rbif.alloc_ready, 0);
        rbif.alloc_req = 1'b1;
        tick();
        rbif.alloc_req = 1'b0;
        chk("ninth_refused", rbif.alloc_ready, 0);
        chk("full_cdb_valid", rbif.CDB_data_valid, 0);

        // Single result: CDB and commit in the same cycle.
        do_reset();
        alloc(1'b0, 3'd2, 0);
        push(3'd2, 32'h2A);
        set_fu(1, 0, 32'h2A);
        tick();
        idle();
        chk("single_cdb_valid", rbif.CDB_data_valid, 8'h01);
        chk("single_cdb_data", rbif.CDB_data_data[0], 32'h2A);
        tick();
        chk("single_retired", rbif.CDB_data_valid, 0);
        chk("single_q_empty", exp_q.size(), 0);

        // Out-of-order results, in-order commits.
        do_reset();
        alloc(1'b0, 3'd3, 0);
        alloc(1'b0, 3'd4, 1);
        push(3'd3, 32'h10);
        push(3'd4, 32'h11);
        set_fu(2, 1, 32'h11);
        tick();
        idle();
        chk("ooo_no_commit", rbif.commit_valid, 0);
        set_fu(0, 0, 32'h10);
        tick();
        idle();
        tick();
        tick();
        chk("ooo_q_empty", exp_q.size(), 0);

        // Same-tag priority, NULL / non-busy tags ignored, parallel captures.
        do_reset();
        alloc(1'b0, 3'd1, 0);
        alloc(1'b0, 3'd5, 1);
        alloc(1'b0, 3'd6, 2);
        push(3'd1, 32'hA);
        push(3'd5, 32'hB);
        push(3'd6, 32'h7);
        set_fu(0, 2, 32'h5);
        set_fu(3, 2, 32'h7);
        set_fu(1, NULL, 32'hDEAD);
        set_fu(2, 5, 32'hBEEF);
        tick();
        idle();
        chk("prio_value", rbif.CDB_data_data[2], 32'h7);
        chk("prio_cdb_valid", rbif.CDB_data_valid, 8'h04);
        chk("null_entry0", rbif.CDB_data_data[0], 0);
        chk("nonbusy_entry5", rbif.CDB_data_data[5], 0);
        set_fu(0, 0, 32'hA);
        set_fu(1, 1, 32'hB);
        tick();
        idle();
        chk("multi_cdb_valid", rbif.CDB_data_valid, 8'h07);
        tick();
        tick();
        tick();
        chk("prio_q_empty", exp_q.size(), 0);

        // Taken branch flushes everything.
        do_reset();
        alloc(1'b1, 3'd0, 0);
        alloc(1'b0, 3'd5, 1);
        alloc(1'b0, 3'd6, 2);
        set_fu(0, 0, 32'h1);
        tick();
        idle();
        chk("taken_flush", rbif.flush, 1);
        chk("taken_reset_bus", rbif.reset_bus, 4'hF);
        chk("taken_alloc_ready", rbif.alloc_ready, 0);
        rbif.alloc_req = 1'b1;
        set_fu(1, 1, 32'h99);
        tick();
        idle();
        chk("post_flush_pulse", rbif.flush, 0);
        chk("post_flush_reset_bus", rbif.reset_bus, 0);
        chk("post_flush_cdb_valid", rbif.CDB_data_valid, 0);
        chk("post_flush_alloc_ready", rbif.alloc_ready, 1);
        chk("post_flush_index", rbif.alloc_index, 0);
        set_fu(1, 2, 32'h55);
        tick();
        idle();
        chk("post_flush_ignored", rbif.CDB_data_valid, 0);
        alloc(1'b0, 3'd0, 0);

        // Not-taken branch retires silently.
        do_reset();
        alloc(1'b1, 3'd0, 0);
        alloc(1'b0, 3'd5, 1);
        alloc(1'b0, 3'd6, 2);
        push(3'd5, 32'h51);
        push(3'd6, 32'h62);
        set_fu(0, 0, 32'h0);
        set_fu(1, 1, 32'h51);
        set_fu(2, 2, 32'h62);
        tick();
        idle();
        chk("nt_no_flush", rbif.flush, 0);
        chk("nt_cdb_valid", rbif.CDB_data_valid, 8'h07);
        tick();
        chk("nt_no_flush2", rbif.flush, 0);
        tick();
        tick();
        chk("nt_q_empty", exp_q.size(), 0);

        // Continuous alloc/commit across the 7->0 wrap.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            idle();
            if (k < 10) begin
                rbif.alloc_req      = 1'b1;
                rbif.alloc_dest_reg = REG_INDEX'(k % 8);
                chk("wrap_alloc_ready", rbif.alloc_ready, 1);
                chk("wrap_alloc_index", rbif.alloc_index, k % 8);
                push(REG_INDEX'(k % 8), 32'h100 + k);
            end
            if (k >= 1 && k <= 10) set_fu(0, (k - 1) % 8, 32'h100 + k - 1);
            tick();
        end
        idle();
        chk("wrap_q_empty", exp_q.size(), 0);

        // Asynchronous reset mid-stream.
        do_reset();
        alloc(1'b0, 3'd1, 0);
        alloc(1'b0, 3'd2, 1);
        push(3'd1, 32'h77);
        set_fu(0, 0, 32'h77);
        set_fu(1, 1, 32'h78);
        tick();
        idle();
        reset = 1'b0;
        #1;
        chk("mid_rst_commit", rbif.commit_valid, 0);
        chk("mid_rst_cdb_valid", rbif.CDB_data_valid, 0);
        chk("mid_rst_cdb_data", |rbif.CDB_data_data, 0);
        chk("mid_rst_flush", rbif.flush, 0);
        chk("mid_rst_index", rbif.alloc_index, 0);
        reset = 1'b1;
        tick();
        tick();
        chk("mid_rst_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
